// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - FSM state encoding and register offsets shared by the interrupt arbiter
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [3:0] IRQ_PENDING  = 4'h0;
  localparam logic [3:0] IRQ_ENABLE   = 4'h4;
  localparam logic [3:0] IRQ_CLAIM    = 4'h8;
  localparam logic [3:0] IRQ_COMPLETE = 4'hC;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - per-source synchronizer with rising-edge or level event detection
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic src_in,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   src_s_d_q, src_s_d_d;
  logic                   src_s;

  assign src_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], src_in};
    src_s_d_d = src_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      src_s_d_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      src_s_d_q <= src_s_d_d;
    end
  end

  assign evt = EDGE ? (src_s & ~src_s_d_q) : src_s;

endmodule

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - fixed-priority interrupt arbiter with pending/enable/claim/complete registers
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int               N_SRC       = 8,
  parameter int               ID_W        = 3,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_SRC-1:0] EDGE_MASK   = {N_SRC{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [3:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  input  logic             reg_we,
  input  logic             reg_re,
  output logic [31:0]      reg_rdata,
  input  logic             trap_ack,
  output logic             e_inter
);

  logic [N_SRC-1:0] evt;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] req_vec;
  logic [ID_W-1:0]  claim_id_q, claim_id_d;
  irq_state_e       state_q, state_d;
  logic             e_inter_q;
  logic [3:0]       addr_w;
  logic             wr_pending, wr_enable, complete_hit;
  logic             unused_ok;

  function automatic logic [ID_W-1:0] pick_winner(input logic [N_SRC-1:0] vec);
    pick_winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (vec[i]) pick_winner = ID_W'(i);
    end
  endfunction

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE       (EDGE_MASK[g])
    ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .src_in(irq_src[g]),
      .evt   (evt[g])
    );
  end

  // Reads are side-effect free, so reg_re and the byte-lane bits carry no function here.
  assign unused_ok = ^{reg_re, reg_addr[1:0], reg_wdata[31:N_SRC]};

  assign addr_w       = {reg_addr[3:2], 2'b00};
  assign wr_pending   = reg_we && (addr_w == IRQ_PENDING);
  assign wr_enable    = reg_we && (addr_w == IRQ_ENABLE);
  assign complete_hit = reg_we && (addr_w == IRQ_COMPLETE) &&
                        (reg_wdata[ID_W-1:0] == claim_id_q);
  assign req_vec      = pending_q & enable_q;

  always_comb begin
    state_d    = state_q;
    claim_id_d = claim_id_q;
    enable_d   = enable_q;
    clr        = '0;
    if (wr_pending) clr = reg_wdata[N_SRC-1:0];
    if (wr_enable)  enable_d = reg_wdata[N_SRC-1:0];
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          claim_id_d = pick_winner(req_vec);
          state_d    = REQ;
        end
      end
      REQ: begin
        // A taken trap wins over a same-cycle mask or W1C withdrawal.
        if (trap_ack) begin
          state_d = SERVICE;
          if (EDGE_MASK[claim_id_q]) clr[claim_id_q] = 1'b1;
        end else if (!enable_q[claim_id_q] || !pending_q[claim_id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (complete_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q & ~clr) | evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      claim_id_q <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      e_inter_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      claim_id_q <= claim_id_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      e_inter_q  <= (state_d == REQ);
    end
  end

  assign e_inter = e_inter_q;

  always_comb begin
    reg_rdata = '0;
    case (addr_w)
      IRQ_PENDING: reg_rdata[N_SRC-1:0] = pending_q;
      IRQ_ENABLE:  reg_rdata[N_SRC-1:0] = enable_q;
      IRQ_CLAIM: begin
        reg_rdata[ID_W-1:0] = claim_id_q;
        reg_rdata[31]       = (state_q == SERVICE);
      end
      default: reg_rdata = '0;
    endcase
  end

endmodule
